// File: rtl/test_delay_line_pkg.sv
// Shared constants for the valid-strobe delay line: legal latency range and default.
package test_delay_line_pkg;

  localparam int DELAY_MIN     = 1;
  localparam int DELAY_MAX     = 64;
  localparam int DELAY_DEFAULT = 4;

  function automatic bit delay_legal(input int delay);
    return (delay >= DELAY_MIN) && (delay <= DELAY_MAX);
  endfunction

endpackage

// File: rtl/test_delay_line_if.sv
// Valid-strobe bundle: the source drives vld_i and observes the delayed vld_o.
interface test_delay_line_if;

  logic vld_i;
  logic vld_o;

  modport master (output vld_i, input vld_o);
  modport slave  (input vld_i, output vld_o);

endinterface

// File: rtl/test_delay_line_vld_dff.sv
// One delay stage: a 1-bit flop cleared asynchronously by an active-low reset.
module vld_dff (
  input  logic clk,
  input  logic rstn,
  input  logic d,
  output logic q
);

  // NOTE: sequential state uses non-blocking (<=) so every stage samples its neighbour's old value.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) q <= 1'b0;
    else       q <= d;
  end

endmodule

// File: rtl/test_delay_line.sv
// Valid-pulse delay line: vld_i reappears on vld_o exactly DELAY rising edges later.
module test_delay_line
  import test_delay_line_pkg::*;
#(
  parameter int DELAY = DELAY_DEFAULT
) (
  input  logic clk,
  input  logic rstn,
  input  logic vld_i,
  output logic vld_o
);

  if (!delay_legal(DELAY)) begin : g_bad_delay
    $error("test_delay_line: DELAY=%0d outside %0d..%0d", DELAY, DELAY_MIN, DELAY_MAX);
  end

  logic [DELAY-1:0] stage;

  for (genvar g = 0; g < DELAY; g++) begin : g_stage
    if (g == 0) begin : g_head
      vld_dff u_dff (.clk(clk), .rstn(rstn), .d(vld_i), .q(stage[0]));
    end else begin : g_body
      vld_dff u_dff (.clk(clk), .rstn(rstn), .d(stage[g-1]), .q(stage[g]));
    end
  end

  // Output comes straight from the last flop, so there is no vld_i -> vld_o path.
  assign vld_o = stage[DELAY-1];

endmodule

// File: tb/tb_test_delay_line.sv
// Bench for test_delay_line: DELAY = 1, 4, 7, 64 driven in parallel against a history-queue model.
module tb_test_delay_line;

  localparam int NDUT = 4;
  localparam int DLY [NDUT] = '{1, 4, 7, 64};

  logic clk;
  logic rstn;
  logic [NDUT-1:0] outs;

  test_delay_line_if bus ();

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    test_delay_line #(.DELAY(DLY[g])) u_dut (
      .clk   (clk),
      .rstn  (rstn),
      .vld_i (bus.vld_i),
      .vld_o (outs[g])
    );
  end
  assign bus.vld_o = outs[1];

  initial begin
    clk = 1'b1;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;
  int edge_no = 0;
  int first_hi [NDUT];
  int hi_cnt [NDUT];
  bit hist [$];

  typedef struct packed {
    bit vin;
    bit exp;
  } vec_t;
  vec_t tbl [11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: output after an edge is the input sampled DELAY-1 edges earlier since the last reset.
  function automatic bit model_out(input int d);
    return (hist.size() >= d) ? hist[d-1] : 1'b0;
  endfunction

  task automatic clear_track();
    for (int g = 0; g < NDUT; g++) begin
      first_hi[g] = -1;
      hi_cnt[g]   = 0;
    end
  endtask

  // Called at a negedge: drive inputs, take one rising edge, compare at the following negedge.
  task automatic cycle(input bit v, input bit r);
    bus.vld_i = v;
    rstn      = r;
    @(posedge clk);
    edge_no++;
    if (!rstn) hist.delete();
    else begin
      hist.push_front(bus.vld_i);
      if (hist.size() > 64) void'(hist.pop_back());
    end
    @(negedge clk);
    for (int g = 0; g < NDUT; g++) begin
      check($sformatf("model D=%0d edge %0d", DLY[g], edge_no), {31'd0, outs[g]}, {31'd0, model_out(DLY[g])});
      if (outs[g]) begin
        hi_cnt[g]++;
        if (first_hi[g] < 0) first_hi[g] = edge_no;
      end
    end
  endtask

  task automatic pulse_test(input int width);
    int start;
    repeat (10) cycle(1'b0, 1'b1);
    clear_track();
    start = edge_no + 1;
    repeat (width) cycle(1'b1, 1'b1);
    repeat (80) cycle(1'b0, 1'b1);
    for (int g = 0; g < NDUT; g++) begin
      check($sformatf("latency D=%0d w=%0d", DLY[g], width), first_hi[g] - start + 1, DLY[g]);
      check($sformatf("width D=%0d w=%0d", DLY[g], width), hi_cnt[g], width);
    end
  endtask

  initial begin
    tbl[0]  = '{1'b1, 1'b0};
    tbl[1]  = '{1'b0, 1'b0};
    tbl[2]  = '{1'b1, 1'b0};
    tbl[3]  = '{1'b1, 1'b1};
    tbl[4]  = '{1'b0, 1'b0};
    tbl[5]  = '{1'b0, 1'b1};
    tbl[6]  = '{1'b1, 1'b1};
    tbl[7]  = '{1'b0, 1'b0};
    tbl[8]  = '{1'b0, 1'b0};
    tbl[9]  = '{1'b0, 1'b1};
    tbl[10] = '{1'b0, 1'b0};

    rstn      = 1'b0;
    bus.vld_i = 1'b0;
    clear_track();
    #1;
    for (int g = 0; g < NDUT; g++) check($sformatf("reset state D=%0d", DLY[g]), {31'd0, outs[g]}, 32'd0);
    #4;
    rstn = 1'b1;

    // Single 2-cycle pulse and 20-cycle continuous valid, latency and width on every instance.
    pulse_test(2);
    pulse_test(20);

    // Reset hold with a toggling input.
    clear_track();
    for (int k = 0; k < 5; k++) cycle(k[0] ^ 1'b1, 1'b0);
    for (int g = 0; g < NDUT; g++) check($sformatf("reset hold D=%0d", DLY[g]), hi_cnt[g], 0);

    // Pattern 1,0,1,1,0,0,1 against the hand-written DELAY=4 table.
    repeat (5) cycle(1'b0, 1'b1);
    for (int i = 0; i < 11; i++) begin
      cycle(tbl[i].vin, 1'b1);
      check($sformatf("pattern step %0d", i), {31'd0, bus.vld_o}, {31'd0, tbl[i].exp});
    end

    // Fill every stage, then assert reset between edges: outputs must clear without a clock.
    repeat (70) cycle(1'b1, 1'b1);
    check("prefill D=64 high", {31'd0, outs[3]}, 32'd1);
    #2 rstn = 1'b0;
    #1;
    for (int g = 0; g < NDUT; g++) check($sformatf("async clear D=%0d", DLY[g]), {31'd0, outs[g]}, 32'd0);
    @(negedge clk);
    cycle(1'b0, 1'b0);
    clear_track();
    repeat (70) cycle(1'b0, 1'b1);
    for (int g = 0; g < NDUT; g++) check($sformatf("no replay D=%0d", DLY[g]), hi_cnt[g], 0);

    // Reset flush: pulse has spent 2 cycles in flight (DELAY-2 for DELAY=4) when reset hits.
    cycle(1'b1, 1'b1);
    cycle(1'b0, 1'b1);
    clear_track();
    cycle(1'b0, 1'b0);
    repeat (70) cycle(1'b0, 1'b1);
    for (int g = 1; g < NDUT; g++) check($sformatf("flush D=%0d", DLY[g]), hi_cnt[g], 0);

    // Random traffic with occasional resets.
    for (int k = 0; k < 600; k++)
      cycle(1'($urandom_range(0, 1)), ($urandom_range(0, 149) != 0));
    repeat (70) cycle(1'b0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
